// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word load-store requests into word-aligned
// DataMemory cycles. Sub-word stores use a read-modify-write pair; loads return
// the addressed lane sign- or zero-extended. Misaligned or reserved-size
// requests complete immediately with resp_err and touch no memory.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, so request inputs are ignored while busy.
// resp_valid is a single-cycle pulse; resp_rdata/resp_err are meaningful only
// while it is high.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [31:0]           MemWD,
  input  logic [31:0]           MemRD,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LD     = 2'd1;
  localparam logic [1:0] S_RMW_RD = 2'd2;
  localparam logic [1:0] S_WR     = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  uns_q;
  logic [31:0]           wdata_q;
  logic [31:0]           merge_q;

  logic                  accept;
  logic                  req_bad;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           ld_data;
  logic [31:0]           merged;

  assign accept    = req_valid && req_ready;
  assign state_dbg = state;

  // Classify the incoming request as reserved-size or misaligned.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Lane extraction and extension of the word read during LD.
  always_comb begin
    lane_b  = MemRD[{addr_q[1:0], 3'b000} +: 8];
    lane_h  = addr_q[1] ? MemRD[31:16] : MemRD[15:0];
    ld_data = MemRD;
    case (size_q)
      SZ_BYTE: ld_data = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: ld_data = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ld_data = MemRD;
    endcase
  end

  // Merge the latched store data into the addressed lane of the read word.
  always_comb begin
    merged = MemRD;
    if (size_q == SZ_BYTE) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Memory-side outputs are driven only in the states that own the bus.
  always_comb begin
    req_ready = (state == S_IDLE);
    MemRead   = (state == S_LD) || (state == S_RMW_RD);
    MemWrite  = (state == S_WR) && !reset;
    MemAddr   = '0;
    MemWD     = '0;
    if (state != S_IDLE) begin
      MemAddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    end
    if (state == S_WR) begin
      MemWD = (size_q == SZ_WORD) ? wdata_q : merge_q;
    end
  end

  // Control FSM, request latches and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_we) begin
              state <= S_LD;
            end else if (req_size == SZ_WORD) begin
              state <= S_WR;
            end else begin
              state <= S_RMW_RD;
            end
          end
        end
        S_LD: begin
          resp_valid <= 1'b1;
          resp_rdata <= we_q ? 32'd0 : ld_data;
          state      <= S_IDLE;
        end
        S_RMW_RD: begin
          merge_q <= merged;
          state   <= S_WR;
        end
        default: begin
          resp_valid <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a behavioural DataMemory, directed scenarios
// and randomized requests checked against a word-array reference model.
module tb_load_store_unit;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] MemAddr;
  logic [31:0]   MemWD;
  logic [31:0]   MemRD;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWD(MemWD), .MemRD(MemRD),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // DataMemory: combinational read, write on the rising edge
  assign MemRD = mem[MemAddr[11:2]];
  always @(posedge clk) begin
    if (MemWrite) mem[MemAddr[11:2]] <= MemWD;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: applies the request to ref_mem using lane arithmetic.
  function automatic void model_req(input logic we, input logic [1:0] size,
                                    input logic uns, input logic [31:0] addr,
                                    input logic [31:0] wdata,
                                    output logic [31:0] rdata, output logic err,
                                    output int lat);
    int a;
    int idx;
    longint word;
    longint v;
    longint width;
    longint shift;
    longint mask;
    a = int'(addr[1:0]);
    idx = int'(addr[11:2]);
    word = longint'(ref_mem[idx]);
    err = (size == 2'd3) || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a != 0);
    rdata = 32'd0;
    lat = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      if (size == 2'd0) begin
        v = (word >> (8 * a)) % 256;
        if (!uns && v >= 128) v = v - 256;
      end else if (size == 2'd1) begin
        v = (word >> (16 * (a / 2))) % 65536;
        if (!uns && v >= 32768) v = v - 65536;
      end else begin
        v = word;
      end
      rdata = v[31:0];
    end else if (size == 2'd2) begin
      lat = 2;
      ref_mem[idx] = wdata;
    end else begin
      lat = 3;
      width = (size == 2'd0) ? 8 : 16;
      shift = (size == 2'd0) ? 8 * a : 16 * (a / 2);
      mask = ((longint'(1) << width) - 1) << shift;
      v = (word & ~mask) | ((longint'(wdata) & ((longint'(1) << width) - 1)) << shift);
      ref_mem[idx] = v[31:0];
    end
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx] = val;
    ref_mem[idx] = val;
  endtask

  // driver: called at a negedge with req_ready high; returns #1 after accept
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_size = 2'($urandom_range(0, 3));
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  // collects the response; lat = 0 means no response within the budget
  task automatic wait_resp(output logic [31:0] rd, output logic err, output int lat,
                           output int nrd, output int nwr, output int rd_cyc,
                           output int wr_cyc, output logic [31:0] wd,
                           output logic [31:0] ma);
    logic done;
    done = 1'b0;
    rd = '0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; rd_cyc = 0; wr_cyc = 0;
    wd = '0; ma = '0;
    for (int i = 1; i <= 8 && !done; i++) begin
      @(negedge clk);
      if (MemRead) begin nrd++; if (rd_cyc == 0) rd_cyc = i; ma = MemAddr; end
      if (MemWrite) begin nwr++; if (wr_cyc == 0) wr_cyc = i; wd = MemWD; ma = MemAddr; end
      if (resp_valid) begin done = 1'b1; lat = i; rd = resp_rdata; err = resp_err; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b exp 0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata: got %h exp 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b exp 0", resp_err); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
    checks++; if ({MemRead, MemWrite} !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl: got %b exp 00", {MemRead, MemWrite}); end
    checks++; if ({MemAddr, MemWD} !== 64'd0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h exp 0/0", MemAddr, MemWD); end
  endtask

  task automatic test_byte_loads;
    logic [31:0] rd, wd, ma; logic err; int lat, nrd, nwr, rc, wc;
    preload(4, 32'h8899AABB);
    send(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    wait_resp(rd, err, lat, nrd, nwr, rc, wc, wd, ma);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_signed_data: got %h exp ffffffaa", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lb_signed_err: got %b exp 0", err); end
    checks++; if (lat != 2) begin errors++; $display("FAIL lb_signed_latency: got %0d exp 2", lat); end
    checks++; if (nrd != 1 || nwr != 0) begin errors++; $display("FAIL lb_signed_memcyc: got rd=%0d wr=%0d exp 1/0", nrd, nwr); end
    checks++; if (ma !== 32'h10) begin errors++; $display("FAIL lb_signed_addr: got %h exp 00000010", ma); end
    send(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    wait_resp(rd, err, lat, nrd, nwr, rc, wc, wd, ma);
    checks++; if (rd !== 32'h00000088) begin errors++; $display("FAIL lbu_data: got %h exp 00000088", rd); end
    checks++; if (lat != 2) begin errors++; $display("FAIL lbu_latency: got %0d exp 2", lat); end
  endtask

  task automatic test_half_store;
    logic [31:0] rd, wd, ma; logic err; int lat, nrd, nwr, rc, wc;
    preload(4, 32'h8899AABB);
    send(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
    wait_resp(rd, err, lat, nrd, nwr, rc, wc, wd, ma);
    checks++; if (rc != 1 || nrd != 1) begin errors++; $display("FAIL sh_read_cycle: got cyc=%0d n=%0d exp 1/1", rc, nrd); end
    checks++; if (wc != 2 || nwr != 1) begin errors++; $display("FAIL sh_write_cycle: got cyc=%0d n=%0d exp 2/1", wc, nwr); end
    checks++; if (wd !== 32'h1234AABB) begin errors++; $display("FAIL sh_memwd: got %h exp 1234aabb", wd); end
    checks++; if (lat != 3) begin errors++; $display("FAIL sh_latency: got %0d exp 3", lat); end
    checks++; if (rd !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL sh_resp: got %h/%b exp 0/0", rd, err); end
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    wait_resp(rd, err, lat, nrd, nwr, rc, wc, wd, ma);
    checks++; if (rd !== 32'h1234AABB) begin errors++; $display("FAIL sh_readback: got %h exp 1234aabb", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, wd, ma; logic err; int lat1, lat2, nrd, nwr, rc, wc;
    send(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
    wait_resp(rd, err, lat1, nrd, nwr, rc, wc, wd, ma);
    checks++; if (wd !== 32'hDEADBEEF || nrd != 0 || nwr != 1) begin errors++; $display("FAIL sw_write: got wd=%h rd=%0d wr=%0d exp deadbeef/0/1", wd, nrd, nwr); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_resp: got %b exp 1", req_ready); end
    send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    wait_resp(rd, err, lat2, nrd, nwr, rc, wc, wd, ma);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_load_data: got %h exp deadbeef", rd); end
    checks++; if (lat1 + lat2 != 4) begin errors++; $display("FAIL b2b_total_cycles: got %0d exp 4", lat1 + lat2); end
  endtask

  task automatic test_errors;
    logic [31:0] rd, wd, ma; logic err; int lat, nrd, nwr, rc, wc;
    logic        t_we   [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  t_size [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] t_addr [3] = '{32'h06, 32'h03, 32'h10};
    for (int k = 0; k < 3; k++) begin
      send(t_we[k], t_size[k], 1'b0, t_addr[k], 32'hFFFF_FFFF);
      wait_resp(rd, err, lat, nrd, nwr, rc, wc, wd, ma);
      checks++; if (err !== 1'b1 || lat != 1) begin errors++; $display("FAIL err_case%0d: got err=%b lat=%0d exp 1/1", k, err, lat); end
      checks++; if (nrd != 0 || nwr != 0 || rd !== 32'd0) begin errors++; $display("FAIL err_case%0d_side: got rd=%0d wr=%0d data=%h exp 0/0/0", k, nrd, nwr, rd); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || MemRead !== 1'b0) begin errors++; $display("FAIL err_case%0d_drop: got v=%b e=%b rd=%b exp 0/0/0", k, resp_valid, resp_err, MemRead); end
    end
  endtask

  task automatic test_reset_mid;
    int seen_wr, seen_v;
    seen_wr = 0; seen_v = 0;
    preload(4, 32'h8899AABB);
    send(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055);
    reset = 1'b1;
    @(negedge clk);
    if (MemWrite) seen_wr++;
    if (resp_valid) seen_v++;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_mid_resp: got rdy=%b v=%b e=%b d=%h exp 1/0/0/0", req_ready, resp_valid, resp_err, resp_rdata); end
    checks++; if (MemRead !== 1'b0 || MemWrite !== 1'b0 || MemAddr !== 32'd0 || MemWD !== 32'd0) begin errors++; $display("FAIL rst_mid_bus: got r=%b w=%b a=%h d=%h exp 0", MemRead, MemWrite, MemAddr, MemWD); end
    repeat (3) begin
      @(negedge clk);
      if (MemWrite) seen_wr++;
      if (resp_valid) seen_v++;
    end
    checks++; if (seen_wr != 0 || seen_v != 0) begin errors++; $display("FAIL rst_mid_activity: got wr=%0d v=%0d exp 0/0", seen_wr, seen_v); end
    checks++; if (mem[4] !== 32'h8899AABB) begin errors++; $display("FAIL rst_mid_mem: got %h exp 8899aabb", mem[4]); end
    // reset while the write is on the bus must suppress it
    preload(16, 32'h0BADF00D);
    send(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_wr_gate: got %b exp 0", MemWrite); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (mem[16] !== 32'h0BADF00D) begin errors++; $display("FAIL rst_wr_mem: got %h exp 0badf00d", mem[16]); end
  endtask

  task automatic test_random;
    logic [31:0] rd, wd, ma, addr, wdata, exp_rd, exp_ma; logic err, exp_err;
    int lat, exp_lat, nrd, nwr, rc, wc;
    logic we, uns; logic [1:0] size;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      addr = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 255));
      wdata = $urandom;
      model_req(we, size, uns, addr, wdata, exp_rd, exp_err, exp_lat);
      exp_q.push_back(exp_rd);
      exp_ma = {addr[31:2], 2'b00};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(we, size, uns, addr, wdata);
      wait_resp(rd, err, lat, nrd, nwr, rc, wc, wd, ma);
      exp_rd = exp_q.pop_front();
      checks++; if (rd !== exp_rd || err !== exp_err) begin errors++; $display("FAIL rand%0d_resp: got %h/%b exp %h/%b", n, rd, err, exp_rd, exp_err); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d exp %0d", n, lat, exp_lat); end
      if (exp_err) begin
        checks++; if (nrd + nwr != 0) begin errors++; $display("FAIL rand%0d_err_bus: got %0d cycles exp 0", n, nrd + nwr); end
      end else begin
        checks++; if (ma !== exp_ma) begin errors++; $display("FAIL rand%0d_addr: got %h exp %h", n, ma, exp_ma); end
      end
    end
    for (int i = 0; i < 64; i++) begin
      checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL rand_mem[%0d]: got %h exp %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    test_reset;
    test_byte_loads;
    test_half_store;
    test_back_to_back;
    test_errors;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
